// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_arb_pkg                                                     |
// | Shared types and constants for the data-memory arbiter.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int NPORTS = 2;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2                                                             |
// | Combinational two-way round-robin chooser with a one-hot grant.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick2
    import data_mem_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req_i,
    input  logic              last_i,
    output logic [NPORTS-1:0] grant_o
);

    always_comb begin
        grant_o = req_i;
        // On contention the port that was not served last wins.
        if (req_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_arbiter                                                     |
// | Round-robin, lockable two-port arbiter for a single-port memory.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int W       = 8,
    parameter int A       = 8,
    parameter int MAXLOCK = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req0,
    input  logic         Req1,
    input  logic         We0,
    input  logic         We1,
    input  logic         Lock0,
    input  logic         Lock1,
    input  logic [A-1:0] Addr0,
    input  logic [A-1:0] Addr1,
    input  logic [W-1:0] WData0,
    input  logic [W-1:0] WData1,
    output logic         Gnt0,
    output logic         Gnt1,
    output logic         RValid0,
    output logic         RValid1,
    output logic [W-1:0] RData0,
    output logic [W-1:0] RData1,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    localparam int            LW        = $clog2(MAXLOCK) + 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(MAXLOCK - 1);
    localparam bit            CAN_LOCK  = (MAXLOCK > 1);

    arb_state_t          state_q, state_d;
    logic                last_q, last_d;
    logic [LW-1:0]       lock_cnt_q, lock_cnt_d;
    logic                rvalid0_q, rvalid1_q;
    logic [W-1:0]        rdata0_q, rdata1_q;

    logic [NPORTS-1:0]   eligible;
    logic [NPORTS-1:0]   pick;
    logic [NPORTS-1:0]   grant;
    logic                lock_sel;
    logic                rd0, rd1;

    // An owned memory is visible only to its owner.
    always_comb begin
        eligible = '0;
        case (state_q)
            IDLE:    eligible = {Req1, Req0};
            OWN0:    eligible = {1'b0, Req0};
            OWN1:    eligible = {Req1, 1'b0};
            default: eligible = '0;
        endcase
    end

    rr_pick2 u_pick (
        .req_i   (eligible),
        .last_i  (last_q),
        .grant_o (pick)
    );

    assign grant      = Reset ? '0 : pick;
    assign Gnt0       = grant[0];
    assign Gnt1       = grant[1];

    assign MemAddress = grant[1] ? Addr1  : Addr0;
    assign MemDataIn  = grant[1] ? WData1 : WData0;
    assign MemWriteEn = (grant[0] & We0) | (grant[1] & We1);

    assign lock_sel   = grant[1] ? Lock1 : Lock0;
    assign rd0        = grant[0] & ~We0;
    assign rd1        = grant[1] & ~We1;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_d     = last_q;
        if (grant != '0) begin
            last_d = grant[1];
        end
        case (state_q)
            IDLE: begin
                if ((grant != '0) && lock_sel && CAN_LOCK) begin
                    state_d    = grant[1] ? OWN1 : OWN0;
                    lock_cnt_d = LW'(1);
                end
            end
            OWN0, OWN1: begin
                // Within ownership a grant can only go to the owner.
                if ((grant != '0) && lock_sel && (lock_cnt_q < LOCK_LAST)) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rd0;
            rvalid1_q  <= rd1;
            if (rd0) begin
                rdata0_q <= MemDataOut;
            end
            if (rd1) begin
                rdata1_q <= MemDataOut;
            end
        end
    end

    assign RValid0 = rvalid0_q;
    assign RValid1 = rvalid1_q;
    assign RData0  = rdata0_q;
    assign RData1  = rdata1_q;

endmodule
`default_nettype wire
